// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain
// Purpose  : Pops bytes one at a time from a FIFO with a registered empty flag
//            and presents each byte on a valid/ready stream, marking the final
//            byte of every FRAME_LEN-byte frame with m_last.
//            Each byte moves IDLE -> POP -> CAPT -> SEND -> IDLE, so the
//            minimum pop-to-pop spacing is 4 cycles.
// Ports    : clk            - clock, rising edge
//            reset          - synchronous active-high reset
//            fifo_underflow - FIFO empty flag (registered inside the FIFO)
//            fifo_data      - FIFO read data, valid the cycle after a strobe
//            fifo_en_read   - FIFO read strobe (one cycle, in POP)
//            m_data         - downstream byte
//            m_valid        - downstream valid
//            m_ready        - downstream ready (looked at only in SEND)
//            m_last         - last byte of the current frame
//            byte_cnt       - bytes delivered, saturating at 255
//            err_timeout    - sticky timeout flag
// Params   : FRAME_LEN   (1..16)  bytes per frame
//            TIMEOUT_CYC (1..255) stalled SEND cycles before a byte is dropped
// Macro    : FIFO_DRAIN_TIMEOUT_EN enables the stall timeout; when undefined
//            SEND waits forever and err_timeout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain #(
  parameter int FRAME_LEN   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_underflow,
  input  logic [7:0] fifo_data,
  output logic       fifo_en_read,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic [7:0] byte_cnt,
  output logic       err_timeout
);

  // Elaboration-time guard on the legal parameter ranges.
  if (FRAME_LEN < 1 || FRAME_LEN > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("fifo_drain: FRAME_LEN must be 1..16 and TIMEOUT_CYC 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic       fifo_en_read_q, fifo_en_read_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_valid_q, m_valid_d;
  logic       m_last_q, m_last_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [3:0] frame_q, frame_d;
  logic [3:0] frame_next;

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT_CYC);
  logic [7:0] stall_q, stall_d;
  logic [7:0] stall_inc;
  logic       err_timeout_q, err_timeout_d;
`endif

  // Frame position after the current byte leaves (delivered or dropped).
  assign frame_next = (frame_q == LAST_IDX) ? 4'd0 : frame_q + 4'd1;

`ifdef FIFO_DRAIN_TIMEOUT_EN
  assign stall_inc = stall_q + 8'd1;
`endif

  always_comb begin
    state_d    = state_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    byte_cnt_d = byte_cnt_q;
    frame_d    = frame_q;
`ifdef FIFO_DRAIN_TIMEOUT_EN
    stall_d       = stall_q;
    err_timeout_d = err_timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_underflow) begin
          state_d = POP;
        end
      end
      POP: begin
        // The empty flag lags the FIFO by a cycle; if it rose while the
        // strobe was out, the read returned nothing and is abandoned.
        state_d = fifo_underflow ? IDLE : CAPT;
      end
      CAPT: begin
        m_data_d  = fifo_data;
        m_valid_d = 1'b1;
        m_last_d  = (frame_q == LAST_IDX);
        state_d   = SEND;
`ifdef FIFO_DRAIN_TIMEOUT_EN
        stall_d   = 8'd0;
`endif
      end
      SEND: begin
        if (m_valid_q && m_ready) begin
          m_valid_d  = 1'b0;
          m_last_d   = 1'b0;
          byte_cnt_d = (byte_cnt_q == 8'hFF) ? 8'hFF : byte_cnt_q + 8'd1;
          frame_d    = frame_next;
          state_d    = IDLE;
        end
`ifdef FIFO_DRAIN_TIMEOUT_EN
        else if (stall_inc == STALL_LIMIT) begin
          // Downstream stalled too long: drop the byte but keep the frame
          // position moving so framing stays aligned with the source.
          m_valid_d     = 1'b0;
          m_last_d      = 1'b0;
          frame_d       = frame_next;
          err_timeout_d = 1'b1;
          stall_d       = stall_inc;
          state_d       = IDLE;
        end else begin
          stall_d = stall_inc;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered strobe: high exactly for the cycle spent in POP.
    fifo_en_read_d = (state_d == POP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      fifo_en_read_q <= 1'b0;
      m_data_q       <= 8'h00;
      m_valid_q      <= 1'b0;
      m_last_q       <= 1'b0;
      byte_cnt_q     <= 8'h00;
      frame_q        <= 4'd0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
      stall_q        <= 8'd0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      fifo_en_read_q <= fifo_en_read_d;
      m_data_q       <= m_data_d;
      m_valid_q      <= m_valid_d;
      m_last_q       <= m_last_d;
      byte_cnt_q     <= byte_cnt_d;
      frame_q        <= frame_d;
`ifdef FIFO_DRAIN_TIMEOUT_EN
      stall_q        <= stall_d;
      err_timeout_q  <= err_timeout_d;
`endif
    end
  end

  assign fifo_en_read = fifo_en_read_q;
  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign byte_cnt     = byte_cnt_q;
`ifdef FIFO_DRAIN_TIMEOUT_EN
  assign err_timeout  = err_timeout_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_drain
// Purpose  : Directed self-checking bench for fifo_drain. A small FIFO model
//            (queue + registered empty flag) feeds two instances sharing all
//            inputs: FRAME_LEN=4 (main) and FRAME_LEN=1 (m_last on every byte).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_drain;

  localparam int TMO = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_ready = 1'b0;
  logic       fifo_underflow;
  logic [7:0] fifo_data;

  logic       fifo_en_read, m_valid, m_last, err_timeout;
  logic [7:0] m_data, byte_cnt;
  logic       fifo_en_read1, m_valid1, m_last1, err_timeout1;
  logic [7:0] m_data1, byte_cnt1;

  // FIFO model
  logic [7:0] q[$];
  logic       model_uf = 1'b1;
  logic [7:0] model_data = 8'h00;
  logic       manual = 1'b0;
  logic       man_uf = 1'b1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  assign fifo_underflow = manual ? man_uf : model_uf;
  assign fifo_data      = model_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_en_read && q.size() > 0) model_data <= q.pop_front();
    else                              model_data <= 8'h00;
    model_uf <= (q.size() == 0);
  end

  fifo_drain #(.FRAME_LEN(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .fifo_underflow(fifo_underflow), .fifo_data(fifo_data),
    .fifo_en_read(fifo_en_read), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .byte_cnt(byte_cnt), .err_timeout(err_timeout)
  );

  fifo_drain #(.FRAME_LEN(1), .TIMEOUT_CYC(TMO)) dut1 (
    .clk(clk), .reset(reset), .fifo_underflow(fifo_underflow), .fifo_data(fifo_data),
    .fifo_en_read(fifo_en_read1), .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1),
    .m_ready(m_ready), .byte_cnt(byte_cnt1), .err_timeout(err_timeout1)
  );

  task automatic do_reset();
    reset   = 1'b1;
    m_ready = 1'b0;
    manual  = 1'b0;
    man_uf  = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (m_valid) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if ({fifo_en_read, m_valid, m_last, err_timeout} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {fifo_en_read, m_valid, m_last, err_timeout}); else pass_cnt++;
    chk_cnt++; if (m_data !== 8'h00) $display("FAIL reset_m_data: got %h expected 00", m_data); else pass_cnt++;
    chk_cnt++; if (byte_cnt !== 8'h00) $display("FAIL reset_byte_cnt: got %h expected 00", byte_cnt); else pass_cnt++;
    chk_cnt++; if ({fifo_en_read1, m_valid1, m_last1, m_data1, byte_cnt1} !== 19'd0) $display("FAIL reset_dut1: got %h expected 0", {fifo_en_read1, m_valid1, m_last1, m_data1, byte_cnt1}); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_single();
    int pop_c = -1;
    int pulses = 0;
    int valid_c = -1;
    logic [7:0] vdata = 8'h00;
    do_reset();
    m_ready = 1'b1;
    q.push_back(8'hA5);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (fifo_en_read) begin pulses++; if (pop_c < 0) pop_c = c; end
      if (m_valid && valid_c < 0) begin valid_c = c; vdata = m_data; end
    end
    chk_cnt++; if (pulses !== 1) $display("FAIL single_pulse_len: got %0d expected 1", pulses); else pass_cnt++;
    chk_cnt++; if (valid_c - pop_c !== 2 || pop_c < 0) $display("FAIL single_latency: got %0d expected 2", valid_c - pop_c); else pass_cnt++;
    chk_cnt++; if (vdata !== 8'hA5) $display("FAIL single_data: got %h expected a5", vdata); else pass_cnt++;
    chk_cnt++; if (byte_cnt !== 8'd1) $display("FAIL single_byte_cnt: got %0d expected 1", byte_cnt); else pass_cnt++;
  endtask

  task automatic test_stream();
    int got = 0;
    int last_pop = -1;
    int gap_bad = 0;
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    for (int c = 0; c < 100 && got < 8; c++) begin
      @(posedge clk); #1;
      if (fifo_en_read) begin
        if (last_pop >= 0 && c - last_pop != 4) gap_bad++;
        last_pop = c;
      end
      if (m_valid && m_ready) begin
        chk_cnt++; if (m_data !== 8'(got + 1)) $display("FAIL stream_data[%0d]: got %h expected %h", got, m_data, 8'(got + 1)); else pass_cnt++;
        chk_cnt++; if (m_last !== (got == 3 || got == 7)) $display("FAIL stream_last[%0d]: got %b expected %b", got, m_last, (got == 3 || got == 7)); else pass_cnt++;
        chk_cnt++; if (m_last1 !== 1'b1) $display("FAIL stream_last_len1[%0d]: got %b expected 1", got, m_last1); else pass_cnt++;
        got++;
      end
    end
    @(posedge clk); #1;
    chk_cnt++; if (got !== 8) $display("FAIL stream_count: got %0d expected 8", got); else pass_cnt++;
    chk_cnt++; if (gap_bad !== 0) $display("FAIL stream_spacing: got %0d bad gaps expected 0", gap_bad); else pass_cnt++;
    chk_cnt++; if (byte_cnt !== 8'd8) $display("FAIL stream_byte_cnt: got %0d expected 8", byte_cnt); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    bit ok;
    int bad = 0;
    int reads = 0;
    do_reset();
    q.push_back(8'h3C);
    q.push_back(8'h3D);
    wait_valid(ok);
    chk_cnt++; if (!ok) $display("FAIL bp_valid_timeout: got no m_valid expected m_valid=1"); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (m_valid !== 1'b1 || m_data !== 8'h3C) bad++;
      if (fifo_en_read) reads++;
    end
    chk_cnt++; if (bad !== 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); else pass_cnt++;
    chk_cnt++; if (reads !== 0) $display("FAIL bp_extra_read: got %0d reads expected 0", reads); else pass_cnt++;
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (m_valid !== 1'b0 || byte_cnt !== 8'd1) $display("FAIL bp_handshake: got valid=%b cnt=%0d expected valid=0 cnt=1", m_valid, byte_cnt); else pass_cnt++;
    wait_valid(ok);
    chk_cnt++; if (!ok || m_data !== 8'h3D) $display("FAIL bp_next_byte: got %h expected 3d", m_data); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (byte_cnt !== 8'd2) $display("FAIL bp_byte_cnt: got %0d expected 2", byte_cnt); else pass_cnt++;
  endtask

  task automatic test_stale_underflow();
    int vcnt = 0;
    int rcnt = 0;
    do_reset();
    manual = 1'b1;
    man_uf = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (fifo_en_read !== 1'b0) $display("FAIL stale_idle: got %b expected 0", fifo_en_read); else pass_cnt++;
    man_uf = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if (fifo_en_read !== 1'b1) $display("FAIL stale_pop: got %b expected 1", fifo_en_read); else pass_cnt++;
    man_uf = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (m_valid) vcnt++;
      if (fifo_en_read) rcnt++;
    end
    chk_cnt++; if (vcnt !== 0 || rcnt !== 0) $display("FAIL stale_no_valid: got valid=%0d reads=%0d expected 0/0", vcnt, rcnt); else pass_cnt++;
    chk_cnt++; if (byte_cnt !== 8'd0) $display("FAIL stale_byte_cnt: got %0d expected 0", byte_cnt); else pass_cnt++;
    manual = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen = 0;
    do_reset();
    m_ready = 1'b1;
    q.push_back(8'h11);
    for (int i = 0; i < 40 && byte_cnt != 8'd1; i++) begin @(posedge clk); #1; end
    chk_cnt++; if (byte_cnt !== 8'd1) $display("FAIL rmid_first: got %0d expected 1", byte_cnt); else pass_cnt++;
    m_ready = 1'b0;
    q.push_back(8'h77);
    wait_valid(ok);
    chk_cnt++; if (!ok || m_data !== 8'h77) $display("FAIL rmid_pending: got %h expected 77", m_data); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_cnt++; if (m_valid !== 1'b0 || m_data !== 8'h00 || byte_cnt !== 8'd0) $display("FAIL rmid_cleared: got valid=%b data=%h cnt=%0d expected 0/00/0", m_valid, m_data, byte_cnt); else pass_cnt++;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_valid || fifo_en_read) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL rmid_no_replay: got %0d active cycles expected 0", seen); else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 260; i++) q.push_back(8'(i));
    for (int i = 0; i < 1200 && q.size() > 0; i++) begin @(posedge clk); #1; end
    repeat (8) @(posedge clk);
    #1;
    chk_cnt++; if (q.size() !== 0) $display("FAIL sat_drained: got %0d left expected 0", q.size()); else pass_cnt++;
    chk_cnt++; if (byte_cnt !== 8'hFF) $display("FAIL sat_byte_cnt: got %0d expected 255", byte_cnt); else pass_cnt++;
  endtask

`ifdef FIFO_DRAIN_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int send_cyc = 0;
    do_reset();
    q.push_back(8'h5A);
    wait_valid(ok);
    chk_cnt++; if (!ok) $display("FAIL tmo_valid_timeout: got no m_valid expected m_valid=1"); else pass_cnt++;
    send_cyc = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m_valid) send_cyc++; else break;
    end
    chk_cnt++; if (send_cyc !== TMO) $display("FAIL tmo_cycles: got %0d expected %0d", send_cyc, TMO); else pass_cnt++;
    chk_cnt++; if (err_timeout !== 1'b1 || byte_cnt !== 8'd0) $display("FAIL tmo_flag: got err=%b cnt=%0d expected 1/0", err_timeout, byte_cnt); else pass_cnt++;
    m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_cnt++; if (err_timeout !== 1'b1 || m_valid !== 1'b0) $display("FAIL tmo_sticky: got err=%b valid=%b expected 1/0", err_timeout, m_valid); else pass_cnt++;
  endtask
`else
  task automatic test_timeout();
    bit ok;
    do_reset();
    q.push_back(8'h5A);
    wait_valid(ok);
    chk_cnt++; if (!ok) $display("FAIL notmo_valid_timeout: got no m_valid expected m_valid=1"); else pass_cnt++;
    repeat (40) @(posedge clk);
    #1;
    chk_cnt++; if (m_valid !== 1'b1 || m_data !== 8'h5A || err_timeout !== 1'b0) $display("FAIL notmo_hold: got valid=%b data=%h err=%b expected 1/5a/0", m_valid, m_data, err_timeout); else pass_cnt++;
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (m_valid !== 1'b0 || byte_cnt !== 8'd1) $display("FAIL notmo_release: got valid=%b cnt=%0d expected 0/1", m_valid, byte_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_stale_underflow();
    test_reset_mid();
    test_timeout();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 The module SHALL have parameter FRAME_LEN, default 4, meaning bytes per frame; the legal range is 1..16.
REQ-002 The module SHALL have parameter TIMEOUT_CYC, default 255, meaning stall cycles in SEND before a byte is dropped; the legal range is 1..255.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port fifo_underflow, input, 1 bit: the FIFO empty flag, registered in the FIFO.
REQ-006 The module SHALL have port fifo_data, input, 8 bits: the FIFO read data, valid the cycle after a read strobe, 0 otherwise.
REQ-007 The module SHALL have port fifo_en_read, output, 1 bit: the FIFO read strobe.
REQ-008 The module SHALL have port m_data, output, 8 bits: the downstream byte.
REQ-009 The module SHALL have port m_valid, output, 1 bit: the downstream valid.
REQ-010 The module SHALL have port m_last, output, 1 bit: the last byte of the current frame, qualified by m_valid.
REQ-011 The module SHALL have port m_ready, input, 1 bit: the downstream ready.
REQ-012 The module SHALL have port byte_cnt, output, 8 bits: bytes delivered, saturating at 255.
REQ-013 The module SHALL have port err_timeout, output, 1 bit: a sticky timeout flag.

Function
REQ-014 The FSM SHALL have exactly 4 states: IDLE, POP, CAPT, SEND; all outputs are registered.
REQ-015 In IDLE, when fifo_underflow=0 the FSM SHALL go to POP at the next edge; otherwise it stays in IDLE.
REQ-016 In POP, fifo_en_read SHALL be 1 for exactly one cycle; fifo_en_read is 0 in all other states.
REQ-017 In POP, when fifo_underflow=1 (stale flag) the read is void and the FSM SHALL return to IDLE with no m_valid.
REQ-018 Otherwise POP SHALL go to CAPT.
REQ-019 In CAPT, fifo_data SHALL be loaded into m_data, m_valid set to 1, and m_last set to 1 when the frame counter equals FRAME_LEN-1; the FSM then goes to SEND.
REQ-020 In SEND, m_data, m_valid and m_last SHALL stay stable until m_valid=1 and m_ready=1 at an edge (handshake).
REQ-021 On the handshake, m_valid and m_last SHALL be cleared, byte_cnt incremented (saturating at 255), the frame counter advanced, and the FSM sent to IDLE.
REQ-022 Frame counter: 4 bits; wraps from FRAME_LEN-1 to 0; with FRAME_LEN=1, m_last SHALL be 1 on every byte.
REQ-023 Minimum pop-to-pop spacing SHALL be 4 cycles (IDLE, POP, CAPT, SEND), which tolerates the one-cycle lag of the registered underflow flag.
REQ-024 Latency from fifo_en_read=1 to m_valid=1 SHALL be 2 cycles.
REQ-025 m_ready=1 already asserted on entering SEND SHALL complete the handshake on the first SEND edge.
REQ-026 m_ready SHALL be ignored outside SEND.
REQ-027 fifo_data SHALL be ignored outside CAPT.

Reset
REQ-028 While reset=1 at an edge, the FSM SHALL go to IDLE and all outputs SHALL be 0: fifo_en_read, m_data=8'h00, m_valid, m_last, byte_cnt=8'h00, err_timeout.
REQ-029 Reset SHALL also clear the frame counter and the stall counter.
REQ-030 Reset asserted mid-transfer (in POP, CAPT or SEND) SHALL discard the in-flight byte; it is never presented again.
REQ-031 reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-032 The timeout feature SHALL be controlled by macro FIFO_DRAIN_TIMEOUT_EN.
REQ-033 With FIFO_DRAIN_TIMEOUT_EN defined, an 8-bit stall counter SHALL count SEND cycles with m_ready=0.
REQ-034 With the macro defined, when the stall counter reaches TIMEOUT_CYC the byte SHALL be dropped: m_valid=0, byte_cnt unchanged, frame counter advanced, err_timeout=1 (sticky until reset), FSM to IDLE.
REQ-035 With the macro defined, the stall counter SHALL clear on every entry to SEND.
REQ-036 Without FIFO_DRAIN_TIMEOUT_EN, no stall counter SHALL exist, SEND SHALL wait indefinitely, and err_timeout SHALL be tied to 0; the port list is unchanged.

Verification
REQ-037 Scenario: FIFO holds 8'hA5; underflow=0; m_ready=1 -> fifo_en_read pulses 1 cycle; m_data=8'hA5, m_valid=1 two cycles later; byte_cnt=1.
REQ-038 Scenario: FRAME_LEN=4; 8 bytes 8'h01..8'h08 streamed with m_ready=1 -> m_last=1 only on 8'h04 and 8'h08; byte_cnt=8; pop spacing = 4 cycles.
REQ-039 Scenario: byte 8'h3C presented; m_ready=0 for 10 cycles, then 1 -> m_data and m_valid stable for all 10 cycles; exactly one handshake; no extra fifo_en_read.
REQ-040 Scenario: fifo_underflow rises to 1 during POP -> no m_valid; FSM back in IDLE; byte_cnt unchanged.
REQ-041 Scenario: reset=1 for one cycle while in SEND with 8'h77 pending -> next cycle m_valid=0, m_data=8'h00, byte_cnt=0; 8'h77 never reappears.
REQ-042 Scenario: FIFO_DRAIN_TIMEOUT_EN defined, TIMEOUT_CYC=5, m_ready held 0 -> m_valid drops after 5 SEND cycles; err_timeout=1 and stays 1; byte_cnt=0.
